oai22_bist_checker: RTL
=======================

# oai22_bist_checker

Exhaustive on-silicon self-test sequencer for the 4-input compound cells in the gp9t3v3 library: drives all 16 input vectors into a cell under test, samples its output after a settle window, and compares against the golden OAI22 or AOI22 function. It sits on the library test-chip next to each instantiated OAI22/AOI22 and reports pass/fail, mismatch count and first failing vector to the scan/readout logic.

## Interface

Parameters:
- SETTLE_CYCLES, 2, extra clock cycles each vector is held before Y is sampled (range 0..15)
- FUNC, 0, golden function: 0 = OAI22 (Y = ~((A0|A1)&(B0|B1))), 1 = AOI22 (Y = ~((A0&A1)|(B0&B1)))

Ports (one clock; reset is asynchronous and active-low):
- CLK  input  1  clock, rising edge
- RN  input  1  asynchronous active-low reset
- start  input  1  begin a run (sampled in IDLE or DONE)
- abort  input  1  cancel a run in progress
- y_obs  input  1  output Y of cell under test
- A0, A1, B0, B1  output  1 each  stimulus to cell under test
- busy  output  1  run in progress
- done  output  1  run complete, results valid (level)
- pass  output  1  done with zero mismatches
- err_cnt  output  5  mismatch count, 0..16
- fail_valid  output  1  at least one mismatch captured
- fail_vec  output  4  first failing vector {A0,A1,B0,B1}

## Operation

- States: IDLE, RUN, DONE.
- IDLE: stimulus = 0, busy = 0, done = 0. start -> RUN; clear err_cnt, fail_valid, fail_vec; vec = 0, settle counter = 0.
- RUN: {A0,A1,B0,B1} = vec (A0 is MSB). Settle counter counts 0..SETTLE_CYCLES; on the edge where it equals SETTLE_CYCLES, sample y_obs and compare with golden(vec). Mismatch: err_cnt += 1; if fail_valid = 0, fail_vec = vec, fail_valid = 1. Then vec += 1, counter = 0. After vec = 15 is sampled -> DONE.
- DONE: stimulus = 0, done = 1, pass = (err_cnt == 0); results held. start -> restart exactly as from IDLE.
- abort in RUN -> IDLE; results cleared; done never asserted. abort outside RUN ignored. abort and start together: abort wins in RUN, start wins in IDLE/DONE.
- start in RUN ignored.
- err_cnt saturates naturally at 16 (5 bits, no wrap possible).
- y_obs driven by the combinational cell output; no synchronizer (same clock domain, settle window covers cell delay).

## Timing

- Reset (RN low, asynchronous): state IDLE; all outputs 0 (A0, A1, B0, B1, busy, done, pass, err_cnt, fail_valid, fail_vec).
- Registered outputs only; stimulus changes on the edge after the previous sample.
- start at edge t: busy = 1 and vec 0 driven from t+1.
- Each vector held SETTLE_CYCLES+1 cycles; y_obs sampled at the last edge of its window.
- Run length 16*(SETTLE_CYCLES+1) cycles; done rises the cycle after the vec 15 sample (48 cycles after start with default).
- RN deasserted mid-run: next run needs fresh start; no partial results survive.

## Structure

- Package oai22_bist_pkg: state enum (IDLE, RUN, DONE), FUNC_OAI22 = 0 / FUNC_AOI22 = 1 constants, function golden(func, vec) returning expected Y.
- One sub-module natural: oai22_bist_golden (combinational, parameter FUNC, input vec[3:0], output y_exp), so the comparator and the bench share one reference.

## Test plan

- FUNC=0, ideal OAI22 model on y_obs, start -> busy 48 cycles, done = 1, pass = 1, err_cnt = 0, fail_valid = 0.
- FUNC=0, y_obs stuck at 1 -> err_cnt = 9, fail_vec = 4'b0101, pass = 0; stuck at 0 -> err_cnt = 7, fail_vec = 4'b0000.
- FUNC=1, ideal OAI22 model on y_obs (wrong cell) -> err_cnt = 6, fail_vec = 4'b0011.
- SETTLE_CYCLES=0 and 15, ideal model -> done after 16 and 256 cycles, pass = 1; each vector held exactly SETTLE_CYCLES+1 cycles.
- abort at cycle 20 of a run -> IDLE next cycle, stimulus = 0, done stays 0, err_cnt = 0; start while busy has no effect on vec sequence.
- RN pulsed low mid-run -> all outputs 0 immediately; start after release completes full run with correct results.

Source files
------------

// File: rtl/oai22_bist_pkg.sv
// rtl/oai22_bist_pkg.sv - shared types, function selectors and golden reference for the OAI22/AOI22 self-test
// Contents: state_t (IDLE, RUN, DONE), FUNC_OAI22/FUNC_AOI22 selectors,
//           golden(func, vec) -> expected Y for vec = {A0,A1,B0,B1}.
package oai22_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FUNC_OAI22 = 0;
  localparam int FUNC_AOI22 = 1;

  // vec bit order is {A0, A1, B0, B1}, A0 in the MSB.
  function automatic logic golden(input int func, input logic [3:0] vec);
    if (func == FUNC_AOI22) begin
      return ~((vec[3] & vec[2]) | (vec[1] & vec[0]));
    end
    return ~((vec[3] | vec[2]) & (vec[1] | vec[0]));
  endfunction

endpackage

// File: rtl/oai22_bist_golden.sv
// rtl/oai22_bist_golden.sv - combinational golden OAI22/AOI22 reference
// Ports: vec[3:0] = {A0,A1,B0,B1} applied vector; y_exp = expected cell output.
module oai22_bist_golden
  import oai22_bist_pkg::*;
#(
  parameter int FUNC = FUNC_OAI22
) (
  input  logic [3:0] vec,
  output logic       y_exp
);

  assign y_exp = golden(FUNC, vec);

endmodule

// File: rtl/oai22_bist_checker.sv
// rtl/oai22_bist_checker.sv - exhaustive 16-vector self-test sequencer for one OAI22/AOI22 cell
// Ports: CLK, RN (async active-low); start, abort run control; y_obs cell output;
//        A0/A1/B0/B1 stimulus; busy, done, pass status; err_cnt[4:0] mismatches;
//        fail_valid / fail_vec[3:0] first failing vector {A0,A1,B0,B1}.
module oai22_bist_checker
  import oai22_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int FUNC          = 0
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       start,
  input  logic       abort,
  input  logic       y_obs,
  output logic       A0,
  output logic       A1,
  output logic       B0,
  output logic       B1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [3:0] fvec_q, fvec_d;
  logic [3:0] stim_q;
  logic       busy_q, done_q, pass_q;
  logic       y_exp;

  oai22_bist_golden #(.FUNC(FUNC)) u_golden (
    .vec   (vec_q),
    .y_exp (y_exp)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 5'd0;
          fv_d    = 1'b0;
          fvec_d  = 4'd0;
        end
      end
      RUN: begin
        if (abort) begin
          // Aborted runs leave nothing behind that could be mistaken for a result.
          state_d = IDLE;
          vec_d   = 4'd0;
          cnt_d   = 4'd0;
          err_d   = 5'd0;
          fv_d    = 1'b0;
          fvec_d  = 4'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          // Last edge of the settle window: y_obs is sampled here.
          if (y_obs != y_exp) begin
            err_d = err_q + 5'd1;
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = vec_q;
            end
          end
          vec_d = vec_q + 4'd1;
          cnt_d = 4'd0;
          if (vec_q == 4'd15) begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from next-state values so every pin is a plain flop output.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 4'd0;
      err_q   <= 5'd0;
      fv_q    <= 1'b0;
      fvec_q  <= 4'd0;
      stim_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
      stim_q  <= (state_d == RUN) ? vec_d : 4'd0;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      pass_q  <= (state_d == DONE) && (err_d == 5'd0);
    end
  end

  assign A0         = stim_q[3];
  assign A1         = stim_q[2];
  assign B0         = stim_q[1];
  assign B1         = stim_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule
